// File: rtl/mc6809_intctl_pkg.sv
// Shared definitions for the MC6809 interrupt controller: register offsets,
// acknowledge FSM states, priority encoder and vector/spurious-vector rule.
package mc6809_intctl_pkg;

  localparam logic [2:0] REG_MASK_LO = 3'd0;
  localparam logic [2:0] REG_MASK_HI = 3'd1;
  localparam logic [2:0] REG_EDGE_LO = 3'd2;
  localparam logic [2:0] REG_EDGE_HI = 3'd3;
  localparam logic [2:0] REG_FSEL_LO = 3'd4;
  localparam logic [2:0] REG_FSEL_HI = 3'd5;
  localparam logic [2:0] REG_PEND_LO = 3'd6;
  localparam logic [2:0] REG_PEND_HI = 3'd7;

  localparam logic [15:0] VEC_IRQ_ADDR  = 16'hFFF8;
  localparam logic [15:0] VEC_FIRQ_ADDR = 16'hFFF6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VEC_IRQ  = 2'd1,
    VEC_FIRQ = 2'd2
  } intctl_state_e;

  // Lowest set index wins; an empty request yields nch, the spurious channel.
  function automatic logic [4:0] prio_winner(input logic [15:0] req, input logic [4:0] nch);
    logic [4:0] win;
    win = nch;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) win = 5'(i);
    end
    return win;
  endfunction

  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [4:0] ch);
    return base + {10'd0, ch, 1'b0};
  endfunction

endpackage

// File: rtl/mc6809_intctl_sync.sv
// One interrupt source: 2-flop synchronizer plus a history flop for rising-edge detect.
module mc6809_intctl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= 3'b000;
    else        sh_q <= {sh_q[1:0], async_in};
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/mc6809_intctl.sv
// MC6809 interrupt controller: masked/prioritised IRQ and FIRQ requests with
// vector-fetch acknowledge. FIRQ routing exists only with MC6809_INTCTL_FIRQ_EN.
//
// state    | meaning
// IDLE     | Intvector tracks the IRQ-group winner every cycle
// VEC_IRQ  | CPU fetching FFF8; vector frozen on latched IRQ channel
// VEC_FIRQ | CPU fetching FFF6; vector frozen on latched FIRQ channel
module mc6809_intctl #(
  parameter int          NCH      = 8,
  parameter logic [15:0] VEC_BASE = 16'hFF00
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [NCH-1:0]   IRQSRC,
  input  logic [15:0]      ADDR,
  input  logic [7:0]       D,
  input  logic             RnW,
  input  logic             CS,
  input  logic             BS,
  input  logic             BA,
  output logic [7:0]       DOut,
  output logic             nIRQ,
  output logic             nFIRQ,
  output logic [15:0]      Intvector
);
  import mc6809_intctl_pkg::*;

  localparam logic [4:0]  NCH5  = 5'(NCH);
  localparam logic [15:0] VALID = 16'((17'd1 << NCH) - 17'd1);
`ifdef MC6809_INTCTL_FIRQ_EN
  localparam bit FIRQ_EN = 1'b1;
`else
  localparam bit FIRQ_EN = 1'b0;
`endif

  logic [15:0] lvl, rise;

  for (genvar g = 0; g < 16; g++) begin : g_ch
    if (g < NCH) begin : g_on
      mc6809_intctl_sync u_sync (
        .clk      (CLK),
        .rst_n    (nRESET),
        .async_in (IRQSRC[g]),
        .level    (lvl[g]),
        .rise     (rise[g])
      );
    end else begin : g_off
      assign lvl[g]  = 1'b0;
      assign rise[g] = 1'b0;
    end
  end

  logic [15:0] mask_q, edge_q, fsel_q, pend_q;
  logic [15:0] mask_d, edge_d, fsel_d, pend_d;
  logic [15:0] pend_vis, irq_req, firq_req, wbyte, bytesel, w1c, ack_clr;
  logic [4:0]  irq_win, firq_win, lat_q, lat_d;
  logic [15:0] intvec_q, intvec_d;
  logic        wr_en, vf_irq, vf_firq;
  intctl_state_e state_q, state_d;

  // A set event in this cycle is already visible, so it wins over any clear.
  assign pend_vis = VALID & ((edge_q & (pend_q | rise)) | (~edge_q & lvl));
  assign irq_req  = pend_vis & mask_q & ~fsel_q;
  assign firq_req = pend_vis & mask_q & fsel_q;
  assign irq_win  = prio_winner(irq_req, NCH5);
  assign firq_win = prio_winner(firq_req, NCH5);

  assign vf_irq  = BS & ~BA & (ADDR == VEC_IRQ_ADDR);
  assign vf_firq = FIRQ_EN & BS & ~BA & (ADDR == VEC_FIRQ_ADDR);

  assign wr_en   = CS & ~RnW;
  assign wbyte   = ADDR[0] ? {D, 8'h00} : {8'h00, D};
  assign bytesel = ADDR[0] ? 16'hFF00 : 16'h00FF;

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    fsel_d = fsel_q;
    w1c    = '0;
    if (wr_en) begin
      case (ADDR[2:1])
        REG_MASK_LO[2:1]: mask_d = VALID & ((mask_q & ~bytesel) | wbyte);
        REG_EDGE_LO[2:1]: edge_d = VALID & ((edge_q & ~bytesel) | wbyte);
        REG_FSEL_LO[2:1]: if (FIRQ_EN) fsel_d = VALID & ((fsel_q & ~bytesel) | wbyte);
        default:          w1c = wbyte;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    intvec_d = intvec_q;
    ack_clr  = '0;
    case (state_q)
      IDLE: begin
        intvec_d = vec_addr(VEC_BASE, irq_win);
        if (vf_irq) begin
          state_d = VEC_IRQ;
          lat_d   = irq_win;
        end else if (vf_firq) begin
          state_d  = VEC_FIRQ;
          lat_d    = firq_win;
          intvec_d = vec_addr(VEC_BASE, firq_win);
        end
      end
      VEC_IRQ, VEC_FIRQ: begin
        if ((state_q == VEC_IRQ) ? !vf_irq : !vf_firq) begin
          state_d  = IDLE;
          intvec_d = vec_addr(VEC_BASE, irq_win);
          if (lat_q < NCH5) ack_clr[lat_q[3:0]] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Level channels keep no stored state; their pending bit is the live level.
  assign pend_d = VALID & edge_q & ((pend_q & ~(w1c | ack_clr)) | rise);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      mask_q   <= '0;
      edge_q   <= '0;
      fsel_q   <= '0;
      pend_q   <= '0;
      state_q  <= IDLE;
      lat_q    <= NCH5;
      intvec_q <= vec_addr(VEC_BASE, NCH5);
      nIRQ     <= 1'b1;
      nFIRQ    <= 1'b1;
    end else begin
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      fsel_q   <= fsel_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      lat_q    <= lat_d;
      intvec_q <= intvec_d;
      nIRQ     <= ~|irq_req;
      nFIRQ    <= FIRQ_EN ? ~|firq_req : 1'b1;
    end
  end

  assign Intvector = intvec_q;

  always_comb begin
    DOut = 8'h00;
    if (CS && RnW) begin
      case (ADDR[2:0])
        REG_MASK_LO: DOut = mask_q[7:0];
        REG_MASK_HI: DOut = mask_q[15:8];
        REG_EDGE_LO: DOut = edge_q[7:0];
        REG_EDGE_HI: DOut = edge_q[15:8];
        REG_FSEL_LO: DOut = fsel_q[7:0];
        REG_FSEL_HI: DOut = fsel_q[15:8];
        REG_PEND_LO: DOut = pend_vis[7:0];
        default:     DOut = pend_vis[15:8];
      endcase
    end
  end

endmodule

// File: tb/tb_mc6809_intctl.sv
// Directed bench for mc6809_intctl (NCH=8, VEC_BASE=FF00); FIRQ checks follow
// MC6809_INTCTL_FIRQ_EN.
module tb_mc6809_intctl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [7:0]  irqsrc = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic        rnw = 1'b1, cs = 1'b0, bs = 1'b0, ba = 1'b0;
  logic [7:0]  dout;
  logic        nirq, nfirq;
  logic [15:0] intvector;
  logic [7:0]  rv;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mc6809_intctl #(.NCH(8), .VEC_BASE(16'hFF00)) dut (
    .CLK(clk), .nRESET(nreset), .IRQSRC(irqsrc), .ADDR(addr), .D(d),
    .RnW(rnw), .CS(cs), .BS(bs), .BA(ba), .DOut(dout),
    .nIRQ(nirq), .nFIRQ(nfirq), .Intvector(intvector)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    @(negedge clk);
    addr = {13'h0, a}; d = v; rnw = 1'b0; cs = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0; rnw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = {13'h0, a}; rnw = 1'b1; cs = 1'b1;
    #1 v = dout;
    cs = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk); irqsrc = irqsrc | m;
    @(negedge clk); irqsrc = irqsrc & ~m;
  endtask

  initial begin
    #12;
    chk("rst_nirq", {15'd0, nirq}, 16'd1);
    chk("rst_nfirq", {15'd0, nfirq}, 16'd1);
    chk("rst_vec", intvector, 16'hFF10);
    rd(3'd6, rv); chk("rst_pend", {8'd0, rv}, 16'h0000);
    @(negedge clk); nreset = 1'b1;

    // edge channel 2: three clock edges from source rise to nIRQ low
    wr(3'd0, 8'h04); wr(3'd2, 8'h04);
    rd(3'd0, rv); chk("mask_rd", {8'd0, rv}, 16'h0004);
    @(negedge clk); irqsrc[2] = 1'b1;
    tick(1); chk("lat_e1", {15'd0, nirq}, 16'd1);
    tick(1); chk("lat_e2", {15'd0, nirq}, 16'd1);
    tick(1); chk("lat_e3", {15'd0, nirq}, 16'd0);
    chk("vec_ch2", intvector, 16'hFF04);
    @(negedge clk); irqsrc[2] = 1'b0;
    tick(3); rd(3'd6, rv); chk("pend_hold", {8'd0, rv}, 16'h0004);
    wr(3'd6, 8'h04); tick(2);
    chk("w1c_nirq", {15'd0, nirq}, 16'd1);
    rd(3'd6, rv); chk("w1c_pend", {8'd0, rv}, 16'h0000);

    // channels 1 and 5, acknowledge of channel 1
    wr(3'd0, 8'h22); wr(3'd2, 8'h22);
    pulse(8'h22); tick(4);
    chk("prio_vec", intvector, 16'hFF02);
    chk("prio_nirq", {15'd0, nirq}, 16'd0);
    @(negedge clk); bs = 1'b1; ba = 1'b0; addr = 16'hFFF8;
    tick(1); chk("ack_vec", intvector, 16'hFF02);
    @(negedge clk); bs = 1'b0; addr = 16'h0000;
    tick(2); chk("post_ack_vec", intvector, 16'hFF0A);
    rd(3'd6, rv); chk("post_ack_pend", {8'd0, rv}, 16'h0020);
    wr(3'd6, 8'h20); tick(2);
    chk("spur_vec", intvector, 16'hFF10);
    chk("spur_nirq", {15'd0, nirq}, 16'd1);

    // level channel 3 ignores write-1-clear
    wr(3'd0, 8'h08); wr(3'd2, 8'h00);
    @(negedge clk); irqsrc[3] = 1'b1;
    tick(4); rd(3'd6, rv); chk("lvl_pend", {8'd0, rv}, 16'h0008);
    chk("lvl_vec", intvector, 16'hFF06);
    wr(3'd6, 8'h08); tick(1);
    rd(3'd6, rv); chk("lvl_w1c_pend", {8'd0, rv}, 16'h0008);
    chk("lvl_w1c_nirq", {15'd0, nirq}, 16'd0);
    @(negedge clk); irqsrc[3] = 1'b0;
    tick(4); chk("lvl_drop_nirq", {15'd0, nirq}, 16'd1);

    // FIRQ routing of channel 0
    wr(3'd4, 8'h01); wr(3'd0, 8'h01); wr(3'd2, 8'h01);
    pulse(8'h01); tick(4);
    rd(3'd4, rv);
`ifdef MC6809_INTCTL_FIRQ_EN
    chk("firq_sel_rd", {8'd0, rv}, 16'h0001);
    chk("firq_nfirq", {15'd0, nfirq}, 16'd0);
    chk("firq_nirq", {15'd0, nirq}, 16'd1);
    chk("firq_idle_vec", intvector, 16'hFF10);
    @(negedge clk); bs = 1'b1; ba = 1'b0; addr = 16'hFFF6;
    tick(1); chk("firq_ack_vec", intvector, 16'hFF00);
    @(negedge clk); bs = 1'b0; addr = 16'h0000;
    tick(2); rd(3'd6, rv); chk("firq_ack_pend", {8'd0, rv}, 16'h0000);
`else
    chk("firq_sel_rd", {8'd0, rv}, 16'h0000);
    chk("firq_nfirq", {15'd0, nfirq}, 16'd1);
    chk("firq_nirq", {15'd0, nirq}, 16'd0);
    chk("firq_idle_vec", intvector, 16'hFF00);
`endif
    wr(3'd6, 8'h01); wr(3'd4, 8'h00);

    // new edge coincident with write-1-clear on channel 2
    wr(3'd0, 8'h04); wr(3'd2, 8'h04);
    pulse(8'h04); tick(4);
    rd(3'd6, rv); chk("race_pre", {8'd0, rv}, 16'h0004);
    @(negedge clk); irqsrc[2] = 1'b1;
    @(posedge clk); @(posedge clk);
    wr(3'd6, 8'h04);
    rd(3'd6, rv); chk("race_pend", {8'd0, rv}, 16'h0004);
    @(negedge clk); irqsrc[2] = 1'b0;
    tick(3); chk("race_nirq", {15'd0, nirq}, 16'd0);

    // reset during VEC_IRQ
    @(negedge clk); bs = 1'b1; ba = 1'b0; addr = 16'hFFF8;
    tick(1); chk("vecirq_vec", intvector, 16'hFF04);
    #1 nreset = 1'b0;
    #1;
    chk("mid_rst_nirq", {15'd0, nirq}, 16'd1);
    chk("mid_rst_nfirq", {15'd0, nfirq}, 16'd1);
    chk("mid_rst_vec", intvector, 16'hFF10);
    @(negedge clk); bs = 1'b0; addr = 16'h0000; nreset = 1'b1;
    tick(2);
    chk("post_rst_vec", intvector, 16'hFF10);
    rd(3'd0, rv); chk("post_rst_mask", {8'd0, rv}, 16'h0000);
    rd(3'd6, rv); chk("post_rst_pend", {8'd0, rv}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
